afifo_rd_unpacker: RTL

AFIFO_RD_UNPACKER -- requirements
Module: afifo_rd_unpacker

---
 rtl/afifo_pkg.sv | 9 +
 rtl/afifo_rd_unpacker.sv | 67 ++++++
 2 files changed

// File: rtl/afifo_pkg.sv
// Shared types for the async FIFO read-side helpers.
package afifo_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    HOLD  = 1'b1
  } rd_state_e;

endpackage

// File: rtl/afifo_rd_unpacker.sv
// Pops one wide word from a show-ahead FIFO and replays it as C_RATIO narrow
// beats, LSB slice first, with zero-bubble reload on the last beat.
module afifo_rd_unpacker
  import afifo_pkg::*;
#(
  parameter int C_WIDTH = 32,
  parameter int C_RATIO = 4
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_fifo_empty,
  input  logic [C_WIDTH-1:0]           i_fifo_data,
  output logic                         o_fifo_ren,
  output logic                         o_m_valid,
  input  logic                         i_m_ready,
  output logic [C_WIDTH/C_RATIO-1:0]   o_m_data,
  output logic                         o_m_last,
  output logic                         o_busy
);

  localparam int BEAT_W = C_WIDTH / C_RATIO;
  localparam int CNT_W  = (C_RATIO > 1) ? $clog2(C_RATIO) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(C_RATIO - 1);

  if ((C_RATIO < 1) || ((C_WIDTH % C_RATIO) != 0)) begin : g_ratio_check
    $fatal(1, "afifo_rd_unpacker: C_WIDTH must be a multiple of C_RATIO");
  end

  rd_state_e          state_q;
  logic [CNT_W-1:0]   beat_q;
  logic [C_WIDTH-1:0] hold_q;

  logic handshake;
  logic lastBeat;

  assign lastBeat   = (state_q == HOLD) && (beat_q == LAST_BEAT);
  assign handshake  = (state_q == HOLD) && i_m_ready;

  // Reset gates the pop so nothing leaves the FIFO before the first clean edge.
  assign o_fifo_ren = i_rst_n && !i_fifo_empty &&
                      ((state_q == EMPTY) || (handshake && lastBeat));

  assign o_m_valid  = (state_q == HOLD);
  assign o_m_last   = lastBeat;
  assign o_busy     = (state_q == HOLD);
  assign o_m_data   = hold_q[int'(beat_q) * BEAT_W +: BEAT_W];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= EMPTY;
      beat_q  <= '0;
      hold_q  <= '0;
    end else if (o_fifo_ren) begin
      hold_q  <= i_fifo_data;
      beat_q  <= '0;
      state_q <= HOLD;
    end else if (handshake) begin
      if (lastBeat) begin
        state_q <= EMPTY;
        beat_q  <= '0;
      end else begin
        beat_q  <= beat_q + CNT_W'(1);
      end
    end
  end

endmodule
